// File: rtl/mtr_drv.sv
// Motor drive PWM stage: offset-binary duty per wheel, shared 11-bit period counter, dead-time per channel.
// Latency: duty latched at period wrap; switch outputs registered, one clk after the driving PWM decision.
// Backpressure: none; free-running, mtr_en gates the switch outputs only (counters keep running).
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_lft_spd, i_rght_spd    signed 12-bit wheel speeds
//   i_mtr_en                 1 = drive, 0 = coast (all switch outputs low)
//   o_lft_PWM1/2             left high-side / low-side drives
//   o_rght_PWM1/2            right high-side / low-side drives
//   o_PWM_synch              1-clk pulse while the period counter is 0

// One wheel: duty latch, PWM comparator, dead-time counter, registered switch drives.
module mtr_drv_ch #(
  parameter logic [5:0] DEADTIME = 6'd32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_spd,
  input  logic [10:0] i_cnt_next,
  input  logic        i_wrap,
  input  logic        i_mtr_en,
  output logic        o_pwm1,
  output logic        o_pwm2
);

  logic [10:0] r_duty_q;
  logic        r_sig;
  logic [5:0]  r_sc;
  logic        r_pwm1;
  logic        r_pwm2;

  logic [10:0] w_duty;
  logic [10:0] w_duty_q_next;
  logic        w_sig_next;
  logic        w_toggle;
  logic [5:0]  w_sc_next;
  logic        w_settled;

  // Signed speed to offset binary, LSB dropped: 0x800 -> 0, 0x000 -> 0x400, 0x7FF -> 0x7FF.
  assign w_duty = {~i_spd[11], i_spd[10:1]};

  // New duty only takes effect on the edge that wraps the counter, so a period is never split.
  assign w_duty_q_next = i_wrap ? w_duty : r_duty_q;

  // Compare against next-state values so PWM_sig is aligned with the counter it is registered beside.
  assign w_sig_next = (i_cnt_next < w_duty_q_next);

  assign w_toggle = w_sig_next ^ r_sig;

  // Stable counter restarts on every toggle and saturates at DEADTIME.
  always_comb begin
    w_sc_next = r_sc;
    if (w_toggle) begin
      w_sc_next = 6'd0;
    end else if (r_sc < DEADTIME) begin
      w_sc_next = r_sc + 6'd1;
    end
  end

  // Both switches stay off until PWM_sig has been stable for DEADTIME edges; the old side
  // drops on the toggle edge because w_sc_next is 0 there.
  assign w_settled = (w_sc_next == DEADTIME);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_q <= 11'h400;
      r_sig    <= 1'b0;
      r_sc     <= 6'd0;
      r_pwm1   <= 1'b0;
      r_pwm2   <= 1'b0;
    end else begin
      r_duty_q <= w_duty_q_next;
      r_sig    <= w_sig_next;
      r_sc     <= w_sc_next;
      r_pwm1   <= w_sig_next  & w_settled & i_mtr_en;
      r_pwm2   <= ~w_sig_next & w_settled & i_mtr_en;
    end
  end

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;

endmodule

module mtr_drv #(
  parameter logic [5:0] DEADTIME = 6'd32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_lft_spd,
  input  logic [11:0] i_rght_spd,
  input  logic        i_mtr_en,
  output logic        o_lft_PWM1,
  output logic        o_lft_PWM2,
  output logic        o_rght_PWM1,
  output logic        o_rght_PWM2,
  output logic        o_PWM_synch
);

  logic [10:0] r_cnt;
  logic        r_synch;
  logic [10:0] w_cnt_next;
  logic        w_wrap;

  assign w_cnt_next = r_cnt + 11'd1;
  assign w_wrap     = (r_cnt == 11'h7FF);

  // Free-running 2048-clk period; synch is registered so it is high exactly while cnt == 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 11'd0;
      r_synch <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_synch <= (w_cnt_next == 11'd0);
    end
  end

  assign o_PWM_synch = r_synch;

  mtr_drv_ch #(.DEADTIME(DEADTIME)) u_lft (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_spd      (i_lft_spd),
    .i_cnt_next (w_cnt_next),
    .i_wrap     (w_wrap),
    .i_mtr_en   (i_mtr_en),
    .o_pwm1     (o_lft_PWM1),
    .o_pwm2     (o_lft_PWM2)
  );

  mtr_drv_ch #(.DEADTIME(DEADTIME)) u_rght (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_spd      (i_rght_spd),
    .i_cnt_next (w_cnt_next),
    .i_wrap     (w_wrap),
    .i_mtr_en   (i_mtr_en),
    .o_pwm1     (o_rght_PWM1),
    .o_pwm2     (o_rght_PWM2)
  );

endmodule
